bitstream_loader: RTL and testbench

- Protocol sequencer between the USB CDC byte stream (OUT direction) and the eFPGA configuration write port.
- Hunts for a sync word, reads a word count, and assembles big-endian 32-bit words, issuing one single-cycle write strobe per word.
- Checks a trailing checksum and returns one status byte on the CDC IN channel.
- Replaces ad-hoc byte bridging with a framed, timeout-protected load sequence.

---
 rtl/loader_pkg.sv | 9 +
 rtl/loader_word_assembler.sv | 50 +++++
 rtl/bitstream_loader.sv | 114 +++++++++++
 tb/tb_bitstream_loader.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// loader_pkg: shared state encoding, response codes and defaults for bitstream_loader
package loader_pkg;
  typedef enum logic [2:0] {SYNC, LEN, DATA, CHK, RESPOND} state_e;
  localparam logic [7:0] RSP_OK = 8'hA5;
  localparam logic [7:0] RSP_CSUM = 8'hE1;
  localparam logic [7:0] RSP_LEN = 8'hE2;
  localparam logic [7:0] RSP_TIMEOUT = 8'hE3;
  localparam logic [31:0] DEF_SYNC_WORD = 32'hFAB0_FAB1;
endpackage

// File: rtl/loader_word_assembler.sv
// loader_word_assembler: byte shift window, big-endian word assembly, checksum and write strobe
module loader_word_assembler (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        clear_i,
  input  logic        acc_i,
  input  logic        data_en_i,
  input  logic [7:0]  data_i,
  output logic [31:0] window_o,
  output logic [7:0]  csum_o,
  output logic        last_o,
  output logic [31:0] word_o,
  output logic        strobe_o
);
  logic [23:0] shift_q, shift_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  csum_q, csum_d;
  logic [31:0] word_q, word_d;
  logic        strobe_q, strobe_d;
  logic        take;
  // Only three bytes of history are stored; the fourth is the byte on the bus.
  assign window_o = {shift_q, data_i};
  assign take = acc_i && data_en_i;
  assign last_o = take && idx_q == 2'd3;
  always_comb begin
    shift_d = clear_i ? 24'd0 : acc_i ? window_o[23:0] : shift_q;
    idx_d = clear_i ? 2'd0 : take ? idx_q + 2'd1 : idx_q;
    csum_d = clear_i ? 8'd0 : take ? csum_q + data_i : csum_q;
    word_d = last_o ? window_o : word_q;
    strobe_d = last_o;
  end
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      shift_q <= '0;
      idx_q <= '0;
      csum_q <= '0;
      word_q <= '0;
      strobe_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      idx_q <= idx_d;
      csum_q <= csum_d;
      word_q <= word_d;
      strobe_q <= strobe_d;
    end
  end
  assign csum_o = csum_q;
  assign word_o = word_q;
  assign strobe_o = strobe_q;
endmodule

// File: rtl/bitstream_loader.sv
// bitstream_loader: framed CDC byte stream to eFPGA config word writes with checksum,
// length check, inter-byte timeout and a single status byte reply.
module bitstream_loader #(
  parameter logic [31:0] SYNC_WORD = loader_pkg::DEF_SYNC_WORD,
  parameter logic [15:0] MAX_WORDS = 16'd4096,
  parameter logic [3:0]  STROBE_GAP = 4'd0,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd12_000_000
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic [7:0]  out_data_i,
  input  logic        out_valid_i,
  output logic        out_ready_o,
  output logic [7:0]  in_data_o,
  output logic        in_valid_o,
  input  logic        in_ready_i,
  output logic [31:0] write_data_o,
  output logic        word_write_strobe_o,
  output logic        busy_o,
  output logic        error_o
);
  import loader_pkg::*;
  state_e      state_q, state_d;
  logic [7:0]  rsp_q, rsp_d;
  logic        err_q, err_d;
  logic [23:0] tmo_q, tmo_d;
  logic [3:0]  gap_q, gap_d;
  logic [7:0]  len_hi_q, len_hi_d;
  logic        lb_q, lb_d;
  logic [15:0] words_q, words_d;
  logic        acc, counting, tmo_hit, sync_hit, last, len_done;
  logic [31:0] window;
  logic [7:0]  csum;
  logic [15:0] n;
  assign acc = out_valid_i && out_ready_o;
  assign n = {len_hi_q, out_data_i};
  assign counting = state_q == LEN || state_q == DATA || state_q == CHK;
  // An accepted byte always beats a timeout landing in the same cycle.
  assign tmo_hit = counting && !acc && tmo_q == TIMEOUT_CYCLES - 24'd1;
  assign sync_hit = state_q == SYNC && acc && window == SYNC_WORD;
  assign len_done = state_q == LEN && acc && lb_q;
  loader_word_assembler u_asm (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (sync_hit || state_q == RESPOND),
    .acc_i     (acc),
    .data_en_i (state_q == DATA),
    .data_i    (out_data_i),
    .window_o  (window),
    .csum_o    (csum),
    .last_o    (last),
    .word_o    (write_data_o),
    .strobe_o  (word_write_strobe_o)
  );
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= SYNC;
      rsp_q <= '0;
      err_q <= 1'b0;
      tmo_q <= '0;
      gap_q <= '0;
      len_hi_q <= '0;
      lb_q <= 1'b0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      rsp_q <= rsp_d;
      err_q <= err_d;
      tmo_q <= tmo_d;
      gap_q <= gap_d;
      len_hi_q <= len_hi_d;
      lb_q <= lb_d;
      words_q <= words_d;
    end
  end
  always_comb begin
    state_d = state_q;
    rsp_d = rsp_q;
    if (tmo_hit) begin
      state_d = RESPOND;
      rsp_d = RSP_TIMEOUT;
    end else begin
      case (state_q)
        SYNC: state_d = sync_hit ? LEN : SYNC;
        LEN: if (len_done) begin
          state_d = (n == 16'd0 || n > MAX_WORDS) ? RESPOND : DATA;
          rsp_d = RSP_LEN;
        end
        DATA: state_d = (last && words_q == 16'd1) ? CHK : DATA;
        CHK: if (acc) begin
          state_d = RESPOND;
          rsp_d = out_data_i == csum ? RSP_OK : RSP_CSUM;
        end
        RESPOND: state_d = in_ready_i ? SYNC : RESPOND;
        default: state_d = SYNC;
      endcase
    end
  end
  always_comb begin
    err_d = sync_hit ? 1'b0 : (state_q != RESPOND && state_d == RESPOND && rsp_d != RSP_OK) ? 1'b1 : err_q;
    tmo_d = (!counting || acc || state_d != state_q) ? 24'd0 : (tmo_q == 24'hFF_FFFF ? tmo_q : tmo_q + 24'd1);
    gap_d = last ? STROBE_GAP : gap_q - {3'd0, gap_q != 4'd0};
    len_hi_d = (state_q == LEN && acc) ? out_data_i : len_hi_q;
    lb_d = state_q == LEN ? lb_q ^ acc : 1'b0;
    words_d = len_done ? n : last ? words_q - 16'd1 : words_q;
  end
  always_comb begin
    out_ready_o = state_q != RESPOND && gap_q == 4'd0;
    in_valid_o = state_q == RESPOND;
    in_data_o = state_q == RESPOND ? rsp_q : 8'd0;
    busy_o = state_q != SYNC;
    error_o = err_q;
  end
endmodule

// File: tb/tb_bitstream_loader.sv
// tb_bitstream_loader: directed scenario bench for bitstream_loader (STROBE_GAP=3, TIMEOUT_CYCLES=100)
module tb_bitstream_loader;
  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic [7:0]  out_data_i = 8'd0;
  logic        out_valid_i = 1'b0;
  logic        in_ready_i = 1'b0;
  logic        out_ready_o, in_valid_o, word_write_strobe_o, busy_o, error_o;
  logic [7:0]  in_data_o;
  logic [31:0] write_data_o;
  int checks = 0;
  int errors = 0;
  int strobes = 0;
  logic [31:0] last_word = 32'd0;

  always #5 clk_i = ~clk_i;

  bitstream_loader #(.STROBE_GAP(4'd3), .TIMEOUT_CYCLES(24'd100)) dut (
    .clk_i               (clk_i),
    .reset_n_i           (reset_n_i),
    .out_data_i          (out_data_i),
    .out_valid_i         (out_valid_i),
    .out_ready_o         (out_ready_o),
    .in_data_o           (in_data_o),
    .in_valid_o          (in_valid_o),
    .in_ready_i          (in_ready_i),
    .write_data_o        (write_data_o),
    .word_write_strobe_o (word_write_strobe_o),
    .busy_o              (busy_o),
    .error_o             (error_o)
  );

  always @(negedge clk_i) if (word_write_strobe_o) begin
    strobes++;
    last_word = write_data_o;
  end

  task automatic do_reset();
    @(negedge clk_i);
    reset_n_i = 1'b0;
    out_valid_i = 1'b0;
    in_ready_i = 1'b0;
    @(posedge clk_i);
    #1;
    @(negedge clk_i);
    reset_n_i = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk_i);
    out_data_i = b;
    out_valid_i = 1'b1;
    while (!out_ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (!out_ready_o) begin
      checks++; errors++;
      $display("FAIL byte_accept: out_ready_o=%b required 1 within 50 cycles", out_ready_o);
    end
    @(posedge clk_i);
    #1;
    out_valid_i = 1'b0;
  endtask

  task automatic send_sync();
    send_byte(8'hFA); send_byte(8'hB0); send_byte(8'hFA); send_byte(8'hB1);
  endtask

  task automatic get_status(input int hold, output logic [7:0] code, output int lat, output bit stable);
    lat = 0;
    stable = 1'b1;
    while (!in_valid_o && lat < 300) begin
      @(posedge clk_i); #1; lat++;
    end
    if (!in_valid_o) begin
      checks++; errors++;
      $display("FAIL status_wait: in_valid_o=%b required 1 within 300 cycles", in_valid_o);
    end
    code = in_data_o;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk_i); #1;
      if (!in_valid_o || in_data_o !== code || out_ready_o) stable = 1'b0;
    end
    @(negedge clk_i);
    in_ready_i = 1'b1;
    @(posedge clk_i); #1;
    in_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({out_ready_o, in_valid_o, in_data_o, write_data_o, word_write_strobe_o, busy_o, error_o} !== {1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b ival=%b idata=%h wdata=%h stb=%b busy=%b err=%b required 1 0 00 00000000 0 0 0",
               out_ready_o, in_valid_o, in_data_o, write_data_o, word_write_strobe_o, busy_o, error_o);
    end
  endtask

  task automatic test_sync_hunt();
    logic [7:0] seq [7] = '{8'h00, 8'hFA, 8'hB0, 8'hFA, 8'hB0, 8'hFA, 8'hB1};
    int s0 = strobes;
    for (int i = 0; i < 6; i++) send_byte(seq[i]);
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL hunt_busy_before: busy_o=%b required 0", busy_o); end
    send_byte(seq[6]);
    checks++;
    if (busy_o !== 1'b1 || error_o !== 1'b0) begin
      errors++; $display("FAIL hunt_busy_after: busy_o=%b error_o=%b required 1 0", busy_o, error_o);
    end
    checks++;
    if (strobes != s0) begin errors++; $display("FAIL hunt_no_strobe: strobes=%0d required %0d", strobes - s0, 0); end
    do_reset();
  endtask

  task automatic load_frame(input logic [7:0] csum_byte, input logic [7:0] exp_code, input int hold, input logic exp_err);
    logic [31:0] w [2] = '{32'h11223344, 32'hAABBCCDD};
    logic [7:0] code;
    int lat;
    bit stable;
    int s0 = strobes;
    send_sync();
    send_byte(8'h00); send_byte(8'h02);
    for (int k = 0; k < 2; k++) begin
      for (int b = 3; b >= 0; b--) send_byte(w[k][b*8 +: 8]);
      checks++;
      if (word_write_strobe_o !== 1'b1 || write_data_o !== w[k]) begin
        errors++; $display("FAIL load_strobe%0d: stb=%b data=%h required 1 %h", k, word_write_strobe_o, write_data_o, w[k]);
      end
      for (int g = 0; g < 3; g++) begin
        checks++;
        if (out_ready_o !== 1'b0) begin errors++; $display("FAIL gap_low%0d_%0d: out_ready_o=%b required 0", k, g, out_ready_o); end
        @(posedge clk_i); #1;
      end
      checks++;
      if (out_ready_o !== 1'b1 || word_write_strobe_o !== 1'b0) begin
        errors++; $display("FAIL gap_end%0d: out_ready_o=%b stb=%b required 1 0", k, out_ready_o, word_write_strobe_o);
      end
    end
    send_byte(csum_byte);
    get_status(hold, code, lat, stable);
    checks++;
    if (code !== exp_code || lat != 0 || !stable) begin
      errors++; $display("FAIL load_status: code=%h lat=%0d stable=%b required %h 0 1", code, lat, stable, exp_code);
    end
    checks++;
    if (strobes - s0 != 2 || last_word !== 32'hAABBCCDD) begin
      errors++; $display("FAIL load_strobe_count: count=%0d last=%h required 2 aabbccdd", strobes - s0, last_word);
    end
    checks++;
    if (in_valid_o !== 1'b0 || busy_o !== 1'b0 || out_ready_o !== 1'b1 || error_o !== exp_err) begin
      errors++; $display("FAIL load_done: ival=%b busy=%b rdy=%b err=%b required 0 0 1 %b", in_valid_o, busy_o, out_ready_o, error_o, exp_err);
    end
  endtask

  task automatic test_normal_load();
    load_frame(8'hB8, 8'hA5, 5, 1'b0);
  endtask

  task automatic test_bad_checksum();
    load_frame(8'hB9, 8'hE1, 2, 1'b1);
    send_byte(8'hFA); send_byte(8'hB0); send_byte(8'hFA);
    checks++;
    if (error_o !== 1'b1) begin errors++; $display("FAIL csum_err_sticky: error_o=%b required 1", error_o); end
    send_byte(8'hB1);
    checks++;
    if (error_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++; $display("FAIL csum_err_clear: error_o=%b busy_o=%b required 0 1", error_o, busy_o);
    end
    do_reset();
  endtask

  task automatic test_len_errors();
    logic [15:0] lens [2] = '{16'h0000, 16'h1001};
    logic [7:0] code;
    int lat;
    bit stable;
    int s0 = strobes;
    for (int i = 0; i < 2; i++) begin
      send_sync();
      send_byte(lens[i][15:8]); send_byte(lens[i][7:0]);
      get_status(1, code, lat, stable);
      checks++;
      if (code !== 8'hE2 || lat != 0 || error_o !== 1'b1) begin
        errors++; $display("FAIL len_err_%h: code=%h lat=%0d err=%b required e2 0 1", lens[i], code, lat, error_o);
      end
    end
    send_sync();
    send_byte(8'h10); send_byte(8'h00);
    repeat (5) @(posedge clk_i);
    #1;
    checks++;
    if (in_valid_o !== 1'b0 || busy_o !== 1'b1 || out_ready_o !== 1'b1) begin
      errors++; $display("FAIL len_max_ok: ival=%b busy=%b rdy=%b required 0 1 1", in_valid_o, busy_o, out_ready_o);
    end
    checks++;
    if (strobes != s0) begin errors++; $display("FAIL len_no_strobe: strobes=%0d required 0", strobes - s0); end
    do_reset();
  endtask

  task automatic test_timeout();
    logic [7:0] code;
    int lat;
    bit stable;
    int s0 = strobes;
    send_sync();
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hAA); send_byte(8'hBB);
    get_status(0, code, lat, stable);
    checks++;
    if (code !== 8'hE3 || lat != 100 || error_o !== 1'b1) begin
      errors++; $display("FAIL timeout_status: code=%h lat=%0d err=%b required e3 100 1", code, lat, error_o);
    end
    checks++;
    if (strobes != s0) begin errors++; $display("FAIL timeout_no_strobe: strobes=%0d required 0", strobes - s0); end
    send_sync();
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h0A);
    get_status(0, code, lat, stable);
    checks++;
    if (code !== 8'hA5 || write_data_o !== 32'h01020304 || error_o !== 1'b0 || strobes - s0 != 1) begin
      errors++; $display("FAIL back_to_back: code=%h data=%h err=%b strobes=%0d required a5 01020304 0 1",
                         code, write_data_o, error_o, strobes - s0);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] code;
    int lat;
    bit stable;
    int s0 = strobes;
    send_sync();
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    test_reset();
    checks++;
    if (strobes != s0) begin errors++; $display("FAIL reset_no_strobe: strobes=%0d required 0", strobes - s0); end
    send_sync();
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    send_byte(8'h38);
    get_status(0, code, lat, stable);
    checks++;
    if (code !== 8'hA5 || write_data_o !== 32'hDEADBEEF || strobes - s0 != 1) begin
      errors++; $display("FAIL reset_reload: code=%h data=%h strobes=%0d required a5 deadbeef 1", code, write_data_o, strobes - s0);
    end
  endtask

  initial begin
    test_reset();
    test_sync_hunt();
    test_normal_load();
    test_bad_checksum();
    test_len_errors();
    test_timeout();
    test_reset_mid_word();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
